// File: rtl/fibonacci_core.sv
// fibonacci_core
//
// Steps through the Fibonacci sequence and presents the current term on user pads [37:8].
// It is the data path behind the Wishbone control block: `switch` starts and stops the
// sequence, and `clock_sel` picks how often it advances, one step every 2^k cycles for
// one-hot bit k. The controller reads the pad bus back to report the current value.
// When the largest representable term has been shown, the next step restarts the
// sequence at 0. That restart raises `wrap_o` for one cycle and increments `wrap_count`.
//
// Ports
//   wb_clk_i    clock for the whole block
//   reset_n     asynchronous active-low reset
//   switch      1 = advance, 0 = hold every piece of state, including the rate phase
//   clock_sel   one-hot advance-rate select; zero or multi-hot stops advancing
//   io_out      {cur, FIB_LSB zeros}
//   io_oeb      constant: upper WIDTH pads driven (0), lower FIB_LSB pads input (1)
//   wrap_o      one-cycle pulse on the cycle the sequence restarts at 0
//   wrap_count  number of restarts, modulo 256
//
// FIB_LSB + WIDTH must equal IO_PADS.

module fibonacci_core #(
  parameter int unsigned CLOCK_WIDTH = 6,
  parameter int unsigned WIDTH       = 30,
  parameter int unsigned IO_PADS     = 38,
  parameter int unsigned FIB_LSB     = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   reset_n,
  input  logic                   switch,
  input  logic [CLOCK_WIDTH-1:0] clock_sel,
  output logic [IO_PADS-1:0]     io_out,
  output logic [IO_PADS-1:0]     io_oeb,
  output logic                   wrap_o,
  output logic [7:0]             wrap_count
);

  localparam int unsigned CntW = CLOCK_WIDTH - 1;

  typedef enum logic [0:0] {StRun, StLast} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       cur_q, cur_d;
  logic [WIDTH-1:0]       nxt_q, nxt_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CLOCK_WIDTH-1:0] sel_q, sel_d;
  logic                   wrap_q, wrap_d;
  logic [7:0]             wrap_count_q, wrap_count_d;

  logic                   sel_valid;
  logic                   rate_change;
  logic                   advance_en;
  logic                   tick;
  logic [CntW-1:0]        tick_mask;
  logic [WIDTH:0]         sum;

  // Rate decode.
  // For one-hot bit k, mask bit j is set exactly when j < k, which gives mask = 2^k - 1.
  // The mask value is irrelevant when clock_sel is not one-hot, because no tick is
  // allowed then.
  always_comb begin
    sel_valid   = (clock_sel != '0) &&
                  ((clock_sel & (clock_sel - CLOCK_WIDTH'(1))) == '0);
    rate_change = (clock_sel != sel_q);
    tick_mask   = '0;
    for (int j = 0; j < int'(CntW); j++) begin
      tick_mask[j] = |(clock_sel >> (j + 1));
    end
    advance_en  = switch && sel_valid && !rate_change;
    tick        = advance_en && ((cnt_q & tick_mask) == tick_mask);
  end

  // Phase counter.
  // A rate change realigns the phase, so the first step at the new rate comes one full
  // period later.
  always_comb begin
    sel_d = clock_sel;
    cnt_d = cnt_q;
    if (rate_change) begin
      cnt_d = '0;
    end else if (advance_en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Sequence step.
  // The carry out of the WIDTH+1-bit sum flags the first term that does not fit.
  // When that happens, StLast keeps the last term that fits on the pads for one more
  // step before the sequence restarts.
  always_comb begin
    sum          = {1'b0, cur_q} + {1'b0, nxt_q};
    state_d      = state_q;
    cur_d        = cur_q;
    nxt_d        = nxt_q;
    wrap_d       = 1'b0;
    wrap_count_d = wrap_count_q;
    if (tick) begin
      unique case (state_q)
        StRun: begin
          cur_d = nxt_q;
          if (!sum[WIDTH]) begin
            nxt_d = sum[WIDTH-1:0];
          end else begin
            state_d = StLast;
          end
        end
        StLast: begin
          cur_d        = '0;
          nxt_d        = WIDTH'(1);
          state_d      = StRun;
          wrap_d       = 1'b1;
          wrap_count_d = wrap_count_q + 8'd1;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRun;
      cur_q        <= '0;
      nxt_q        <= WIDTH'(1);
      cnt_q        <= '0;
      sel_q        <= CLOCK_WIDTH'(1);
      wrap_q       <= 1'b0;
      wrap_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      nxt_q        <= nxt_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      wrap_q       <= wrap_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // The pads take cur straight from its register, so a reset clears them immediately.
  always_comb begin
    io_out     = {cur_q, {FIB_LSB{1'b0}}};
    io_oeb     = {{WIDTH{1'b0}}, {FIB_LSB{1'b1}}};
    wrap_o     = wrap_q;
    wrap_count = wrap_count_q;
  end

endmodule

// File: tb/tb_fibonacci_core.sv
module tb_fibonacci_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        switch = 1'b0;
  logic [5:0]  clock_sel = 6'd1;
  logic [37:0] io_out;
  logic [37:0] io_oeb;
  logic        wrap_o;
  logic [7:0]  wrap_count;

  always #5 clk = ~clk;

  fibonacci_core dut (
    .wb_clk_i   (clk),
    .reset_n    (reset_n),
    .switch     (switch),
    .clock_sel  (clock_sel),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .wrap_o     (wrap_o),
    .wrap_count (wrap_count)
  );

  typedef struct packed {
    logic [29:0] val;
    logic        wrap;
    logic [7:0]  wcnt;
  } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          total = 0;

  // Reference model: the sequence is an index into a table of terms F(0)..F(44).
  // Each step to be taken advances the index.
  int unsigned fib[45];
  int          idx;
  int          phase;
  int          wraps;
  logic [5:0]  sel_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    idx   = 0;
    phase = 0;
    wraps = 0;
    sel_m = 6'd1;
  endtask

  // Drive one cycle of inputs and predict the outputs after the following edge.
  task automatic drive(input logic sw, input logic [5:0] sel);
    int   k;
    int   period;
    logic wrap_e;
    @(negedge clk);
    switch    = sw;
    clock_sel = sel;
    wrap_e    = 1'b0;
    if (sel != sel_m) begin
      phase = 0;
    end else if (sw && $countones(sel) == 1) begin
      k = 0;
      for (int i = 0; i < 6; i++) if (sel[i]) k = i;
      period = 1 << k;
      if ((phase % period) == period - 1) begin
        if (idx == 44) begin
          idx    = 0;
          wraps  = (wraps + 1) % 256;
          wrap_e = 1'b1;
        end else begin
          idx++;
        end
      end
      phase = (phase + 1) % 32;
    end
    sel_m = sel;
    exp_q.push_back('{val: 30'(fib[idx]), wrap: wrap_e, wcnt: 8'(wraps)});
  endtask

  // Monitor: compare every presented cycle against the next queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("value", 64'(io_out[37:8]), 64'(e.val));
        check("wrap_o", 64'(wrap_o), 64'(e.wrap));
        check("wrap_count", 64'(wrap_count), 64'(e.wcnt));
      end
    end
  end

  initial begin
    int guard;
    int r;
    int len;
    logic [5:0] rsel;
    logic rsw;

    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < 45; i++) fib[i] = fib[i-1] + fib[i-2];

    // Reset state.
    #2 reset_n = 1'b0;
    switch    = 1'b1;
    clock_sel = 6'b000001;
    repeat (2) @(posedge clk);
    #2;
    check("reset_io_out", 64'(io_out), 64'd0);
    check("reset_io_oeb", 64'(io_oeb), 64'h00000000FF);
    check("reset_wrap_o", 64'(wrap_o), 64'd0);
    check("reset_wrap_count", 64'(wrap_count), 64'd0);
    model_reset();
    reset_n = 1'b1;

    // First terms at full rate, up to 21.
    repeat (8) drive(1'b1, 6'b000001);
    // Hold at 21, then resume.
    repeat (10) drive(1'b0, 6'b000001);
    repeat (2) drive(1'b1, 6'b000001);

    // Rate 4, then a multi-hot select freezes the value.
    repeat (13) drive(1'b1, 6'b000100);
    repeat (20) drive(1'b1, 6'b000011);

    // Rate 8: run up to the first step, wait 5 cycles, then change to rate 2.
    drive(1'b1, 6'b001000);
    guard = 0;
    r = idx;
    while (idx == r && guard < 40) begin
      drive(1'b1, 6'b001000);
      guard++;
    end
    check("rate8_tick_seen", 64'(guard < 40), 64'd1);
    repeat (5) drive(1'b1, 6'b001000);
    repeat (6) drive(1'b1, 6'b000010);

    // Wrap: run to the largest term, restart, and then reach the largest term again.
    guard = 0;
    while (idx != 44 && guard < 300) begin
      drive(1'b1, 6'b000001);
      guard++;
    end
    check("reach_last", 64'(fib[idx]), 64'd701408733);
    repeat (2) drive(1'b1, 6'b000001);
    guard = 0;
    while (idx != 44 && guard < 100) begin
      drive(1'b1, 6'b000001);
      guard++;
    end
    check("reach_last_again", 64'(guard), 64'd43);

    // Asynchronous reset between edges while the largest term is shown.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_io_out", 64'(io_out), 64'd0);
    check("async_wrap_o", 64'(wrap_o), 64'd0);
    check("async_wrap_count", 64'(wrap_count), 64'd0);
    switch    = 1'b1;
    clock_sel = 6'b000001;
    @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    repeat (4) drive(1'b1, 6'b000001);

    // 256 complete passes bring wrap_count back to 0.
    repeat (256 * 45 - 4) drive(1'b1, 6'b000001);
    check("wrap256_model_count", 64'(wraps), 64'd0);

    // Random segments of switch and rate select.
    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r <= 5) rsel = 6'd1 << r;
      else if (r == 6) rsel = 6'd0;
      else if (r == 7) rsel = 6'($urandom_range(0, 63));
      else rsel = sel_m;
      rsw = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 40);
      repeat (len) drive(rsw, rsel);
    end

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("io_oeb_const", 64'(io_oeb), 64'h00000000FF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fibonacci_core.md
Name: fibonacci_core

Overview:
- Generates the Fibonacci sequence and drives it onto user I/O pads [37:8].
- Sits directly downstream of the Wishbone control block:
  - consumes that block's `switch` (run enable) and `clock_sel` (one-hot rate select);
  - the value it drives is what that block reads back from the pad bus at CTRL_FIBONACCI_VAL.
- Also provides a wrap pulse (usable as an IRQ source) and a wrap counter.

Parameters:
- CLOCK_WIDTH, 6, width of clock_sel; bit k selects one advance every 2^k cycles.
- WIDTH, 30, width of the Fibonacci registers and of the pad field.
- IO_PADS, 38, total pad count.
- FIB_LSB, 8, lowest pad bit carrying the value; requires FIB_LSB+WIDTH == IO_PADS.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- switch  in  1  1 = sequence advances, 0 = hold.
- clock_sel  in  CLOCK_WIDTH  one-hot advance-rate select.
- io_out  out  IO_PADS  {cur, FIB_LSB'b0}.
- io_oeb  out  IO_PADS  {WIDTH'b0, FIB_LSB{1'b1}}: upper bits driven, lower bits input; constant.
- wrap_o  out  1  one-cycle pulse on sequence restart.
- wrap_count  out  8  number of restarts, wraps 255->0.

Behaviour:
Registers:
- cur, nxt: WIDTH bits each.
- state: RUN or LAST.
- cnt: CLOCK_WIDTH-1 bits.
- sel_q: registered clock_sel.
- wrap_o, wrap_count.

Reset (async on reset_n low, in any cycle including mid-advance):
- cur=0, nxt=1, state=RUN, cnt=0, sel_q=clock_sel reset value 1, wrap_o=0, wrap_count=0.
- io_out=0.
- No advance occurs on the first edge after reset release unless the tick condition below holds.

sel_q and rate change:
- sel_q <= clock_sel every cycle.
- When clock_sel != sel_q (a rate change), cnt is cleared on that edge and no advance happens.

Tick:
- valid = clock_sel is exactly one-hot. Zero or multi-hot means no ticks and cnt holds.
- k = index of the set bit; mask = 2^k-1.
- tick = switch & valid & no rate change & ((cnt & mask) == mask).
- cnt increments (mod 2^(CLOCK_WIDTH-1)) on every cycle with switch & valid & no rate change; otherwise it holds.
- Result:
  - k=0: advance every cycle.
  - k=2: advance every 4th cycle; the first advance happens 4 cycles after enable.

Advance on tick edge, with sum = cur + nxt computed at WIDTH+1 bits:
- RUN, sum[WIDTH]==0: cur<=nxt, nxt<=sum[WIDTH-1:0].
- RUN, sum[WIDTH]==1: cur<=nxt, nxt<=don't-care (kept), state<=LAST. This shows the largest representable Fibonacci number.
- LAST: cur<=0, nxt<=1, state<=RUN, wrap_o<=1 for exactly that one cycle, wrap_count<=wrap_count+1.

Other rules:
- wrap_o is 0 on every cycle without a LAST tick.
- switch=0: cur, nxt, state and cnt all hold.
  - Re-asserting switch resumes from the held value; the phase within the current period is preserved.
- io_out updates in the same cycle as cur, i.e. registered with no extra latency.
- Simultaneous switch fall and tick condition: no advance, because switch gates the tick.
- Simultaneous rate change and tick condition: no advance; cnt is cleared.
- WIDTH=30 reference points:
  - max shown value is F(44)=701408733;
  - 44 ticks from reset reach it; the 45th tick returns to 0 and pulses wrap_o.

Test Plan:
1. Reset and first ticks:
   - Stimulus: hold reset_n=0, then release with switch=1, clock_sel=6'b000001.
   - During reset: io_out=0, io_oeb=38'h00000000FF, wrap_o=0, wrap_count=0.
   - After release, io_out[37:8] on successive cycles: 0,1,1,2,3,5,8,13.
2. Rate select:
   - Stimulus: set clock_sel=6'b000100.
   - No advance on the change edge; afterwards io_out[37:8] changes exactly every 4 cycles.
   - Set clock_sel=6'b000011: value frozen for 20 cycles.
3. Wrap:
   - Stimulus: run at rate 1 for 44 ticks.
   - io_out[37:8]=701408733 for one cycle, then 0 with wrap_o=1 for that single cycle, then 1.
   - wrap_count=1; after 256 wraps, wrap_count=0.
4. Hold and resume:
   - Stimulus: deassert switch while value=21 for 10 cycles.
   - Value stays 21; after reasserting switch, the next values are 34, 55.
5. Async reset mid-run:
   - Stimulus: drop reset_n between clock edges while in LAST (value 701408733).
   - io_out goes to 0 immediately without waiting for an edge; wrap_o=0, wrap_count=0.
   - After release, the sequence restarts 0,1,1,2.
6. Rate change during count:
   - Stimulus: at rate 8 (6'b001000), 5 cycles after a tick, switch to rate 2.
   - cnt is cleared and no advance occurs on the change edge; the next advance is exactly 2 cycles later.
